gigatron_video_rx: RTL and testbench

GIGATRON_VIDEO_RX -- requirements
Module: gigatron_video_rx

---
 rtl/gigatron_pkg.sv | 44 ++++
 rtl/gigatron_sync_edge.sv | 47 ++++
 rtl/gigatron_video_rx.sv | 240 ++++++++++++++++++++++++
 tb/tb_gigatron_video_rx.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gigatron_pkg.sv
// -----------------------------------------------------------------------------
// gigatron_pkg
// Shared definitions for the Gigatron video receiver: FSM state encoding,
// positions of the sync bits inside the CPU output byte, colour field width,
// default timing constants and a saturating counter helper.
// -----------------------------------------------------------------------------
package gigatron_pkg;

    // Receiver frame-tracking states
    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VSYNC  = 2'd1,
        ST_VBP    = 2'd2,
        ST_ACTIVE = 2'd3
    } rx_state_e;

    // Bit positions of the active-low sync signals in the CPU output byte
    localparam int HSYNC_BIT = 6;
    localparam int VSYNC_BIT = 7;

    // Colour field: 2 bits each of B,G,R
    localparam int RGB_W = 6;

    // Default timing
    localparam int DEF_H_BP     = 12;
    localparam int DEF_H_ACTIVE = 160;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_V_ACTIVE = 480;

    // Idle value of the {vsync, hsync} pair (both deasserted)
    localparam logic [1:0] SYNC_IDLE = 2'b11;

    // 10-bit increment that sticks at its maximum instead of wrapping
    function automatic logic [9:0] sat_inc10(input logic [9:0] value);
        logic [9:0] result;
        if (value == 10'd1023) begin
            result = value;
        end else begin
            result = value + 10'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/gigatron_sync_edge.sv
// -----------------------------------------------------------------------------
// gigatron_sync_edge
// Keeps the previous valid sample of the {vsync, hsync} pair and flags rising
// and falling edges of the current valid sample against it. Strobes are only
// ever high on cycles where i_valid is high.
//
// Ports:
//   i_clock, i_reset_n     clock, asynchronous active-low reset
//   i_valid                current sync sample is meaningful
//   i_hsync, i_vsync       current sync levels (active-low signals)
//   o_hs_rise/o_hs_fall    hsync edge strobes (combinational)
//   o_vs_rise/o_vs_fall    vsync edge strobes (combinational)
// -----------------------------------------------------------------------------
module gigatron_sync_edge
    import gigatron_pkg::*;
(
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_valid,
    input  logic i_hsync,
    input  logic i_vsync,
    output logic o_hs_rise,
    output logic o_hs_fall,
    output logic o_vs_rise,
    output logic o_vs_fall
);

    // r_prev_sync[1] = vsync, r_prev_sync[0] = hsync
    logic [1:0] r_prev_sync;

    // Previous-sample register; reset to idle so release never looks like an edge
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_prev_sync <= SYNC_IDLE;
        end else if (i_valid) begin
            r_prev_sync <= {i_vsync, i_hsync};
        end else begin
            r_prev_sync <= r_prev_sync;
        end
    end

    assign o_hs_rise = i_valid & ~r_prev_sync[0] &  i_hsync;
    assign o_hs_fall = i_valid &  r_prev_sync[0] & ~i_hsync;
    assign o_vs_rise = i_valid & ~r_prev_sync[1] &  i_vsync;
    assign o_vs_fall = i_valid &  r_prev_sync[1] & ~i_vsync;

endmodule

// File: rtl/gigatron_video_rx.sv
// -----------------------------------------------------------------------------
// gigatron_video_rx
// Recovers pixels from the Gigatron CPU output byte stream. Tracks frames via
// vsync (SEARCH -> VSYNC -> VBP -> ACTIVE), counts lines on hsync rising edges
// and emits one registered pixel per valid sample inside the active window.
//
// Optional feature: define GIGATRON_VIDEO_RX_STATS_EN to add frame statistics
// outputs (o_frame_count, o_lines_per_frame).
//
// Ports:
//   i_clock, i_reset_n   clock, asynchronous active-low reset
//   i_valid              qualifies i_out for one CPU cycle
//   i_out[7:0]           [5:0] colour, [6] hsync_n, [7] vsync_n
//   o_px_valid           pixel strobe (latency 1 from the sample)
//   o_px_x, o_px_y       pixel column / row
//   o_px_rgb             pixel colour
//   o_frame_start        pulse on vsync falling edge
//   o_short_frame        pulse when an active frame is cut short by vsync
//   o_frame_count        (stats) frames seen, wrapping
//   o_lines_per_frame    (stats) hsync rises in the last complete frame
// -----------------------------------------------------------------------------
module gigatron_video_rx
    import gigatron_pkg::*;
#(
    parameter int H_BP     = DEF_H_BP,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int V_BP     = DEF_V_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_valid,
    input  logic [7:0]       i_out,
    output logic             o_px_valid,
    output logic [7:0]       o_px_x,
    output logic [8:0]       o_px_y,
    output logic [RGB_W-1:0] o_px_rgb,
    output logic             o_frame_start,
    output logic             o_short_frame
`ifdef GIGATRON_VIDEO_RX_STATS_EN
    ,
    output logic [15:0]      o_frame_count,
    output logic [9:0]       o_lines_per_frame
`endif
);

    localparam logic [9:0] L_H_START = 10'(H_BP);
    localparam logic [9:0] L_H_END   = 10'(H_BP + H_ACTIVE);
    localparam logic [9:0] L_V_BP    = 10'(V_BP);
    localparam logic [8:0] L_V_ACT   = 9'(V_ACTIVE);

    logic w_hs_rise;
    logic w_vs_rise;
    logic w_vs_fall;
    // hsync falls have no role in line timing; the detector still produces them
    logic w_hs_fall_unused;

    rx_state_e        r_state, w_state_nx;
    logic [9:0]       r_h, w_h_cur;
    logic [9:0]       r_line, w_line_nx;
    logic [8:0]       r_row, w_row_nx;
    logic             r_row_open, w_row_open_nx;
    logic             w_px_hit;
    logic [7:0]       w_px_x;
    logic             w_frame_start;
    logic             w_short_frame;

    logic             r_px_valid;
    logic [7:0]       r_px_x;
    logic [8:0]       r_px_y;
    logic [RGB_W-1:0] r_px_rgb;
    logic             r_frame_start;
    logic             r_short_frame;

    gigatron_sync_edge u_sync_edge (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_valid   (i_valid),
        .i_hsync   (i_out[HSYNC_BIT]),
        .i_vsync   (i_out[VSYNC_BIT]),
        .o_hs_rise (w_hs_rise),
        .o_hs_fall (w_hs_fall_unused),
        .o_vs_rise (w_vs_rise),
        .o_vs_fall (w_vs_fall)
    );

    // Next-state, counter and pixel-hit logic
    always_comb begin
        w_state_nx    = r_state;
        w_h_cur       = r_h;
        w_line_nx     = r_line;
        w_row_nx      = r_row;
        w_row_open_nx = r_row_open;
        w_px_hit      = 1'b0;
        w_frame_start = 1'b0;
        w_short_frame = 1'b0;
        w_px_x        = 8'(w_h_cur - L_H_START);

        if (i_valid) begin
            // Horizontal position of this sample: 0 on the hsync rise
            if (w_hs_rise) begin
                w_h_cur = 10'd0;
            end else begin
                w_h_cur = sat_inc10(r_h);
            end
            w_px_x = 8'(w_h_cur - L_H_START);

            // A vsync fall overrides everything, including a coincident hsync edge
            if (w_vs_fall) begin
                w_state_nx    = ST_VSYNC;
                w_row_open_nx = 1'b0;
                w_frame_start = 1'b1;
                if ((r_state == ST_ACTIVE) && (r_row < L_V_ACT)) begin
                    w_short_frame = 1'b1;
                end else begin
                    w_short_frame = 1'b0;
                end
            end else begin
                case (r_state)
                    ST_SEARCH: begin
                        w_state_nx = ST_SEARCH;
                    end
                    ST_VSYNC: begin
                        if (w_vs_rise) begin
                            w_state_nx = ST_VBP;
                            w_line_nx  = 10'd0;
                        end else begin
                            w_state_nx = ST_VSYNC;
                        end
                    end
                    ST_VBP: begin
                        if (w_hs_rise) begin
                            w_line_nx = r_line + 10'd1;
                            if ((r_line + 10'd1) >= L_V_BP) begin
                                w_state_nx    = ST_ACTIVE;
                                w_row_nx      = 9'd0;
                                w_row_open_nx = 1'b0;
                            end else begin
                                w_state_nx = ST_VBP;
                            end
                        end else begin
                            w_state_nx = ST_VBP;
                        end
                    end
                    ST_ACTIVE: begin
                        // The first hsync rise in ACTIVE opens row 0; later ones advance it
                        if (w_hs_rise) begin
                            if (!r_row_open) begin
                                w_row_open_nx = 1'b1;
                            end else if ((r_row + 9'd1) == L_V_ACT) begin
                                w_state_nx    = ST_SEARCH;
                                w_row_open_nx = 1'b0;
                            end else begin
                                w_row_nx = r_row + 9'd1;
                            end
                        end else if (r_row_open && (w_h_cur >= L_H_START) && (w_h_cur < L_H_END)) begin
                            w_px_hit = 1'b1;
                        end else begin
                            w_px_hit = 1'b0;
                        end
                    end
                    default: begin
                        w_state_nx = ST_SEARCH;
                    end
                endcase
            end
        end else begin
            w_h_cur = r_h;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state       <= ST_SEARCH;
            r_h           <= 10'd0;
            r_line        <= 10'd0;
            r_row         <= 9'd0;
            r_row_open    <= 1'b0;
            r_px_valid    <= 1'b0;
            r_px_x        <= 8'd0;
            r_px_y        <= 9'd0;
            r_px_rgb      <= {RGB_W{1'b0}};
            r_frame_start <= 1'b0;
            r_short_frame <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_h           <= w_h_cur;
            r_line        <= w_line_nx;
            r_row         <= w_row_nx;
            r_row_open    <= w_row_open_nx;
            r_px_valid    <= w_px_hit;
            r_frame_start <= w_frame_start;
            r_short_frame <= w_short_frame;
            if (w_px_hit) begin
                r_px_x   <= w_px_x;
                r_px_y   <= r_row;
                r_px_rgb <= i_out[RGB_W-1:0];
            end else begin
                r_px_x   <= r_px_x;
                r_px_y   <= r_px_y;
                r_px_rgb <= r_px_rgb;
            end
        end
    end

    assign o_px_valid    = r_px_valid;
    assign o_px_x        = r_px_x;
    assign o_px_y        = r_px_y;
    assign o_px_rgb      = r_px_rgb;
    assign o_frame_start = r_frame_start;
    assign o_short_frame = r_short_frame;

`ifdef GIGATRON_VIDEO_RX_STATS_EN
    logic [15:0] r_frame_count;
    logic [9:0]  r_line_acc;
    logic [9:0]  r_lines_per_frame;

    // Frame counter and per-frame hsync rise count, latched at each vsync fall
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_frame_count     <= 16'd0;
            r_line_acc        <= 10'd0;
            r_lines_per_frame <= 10'd0;
        end else if (w_vs_fall) begin
            r_frame_count     <= r_frame_count + 16'd1;
            r_lines_per_frame <= r_line_acc;
            r_line_acc        <= 10'd0;
        end else if (w_hs_rise) begin
            r_line_acc        <= sat_inc10(r_line_acc);
        end else begin
            r_line_acc        <= r_line_acc;
        end
    end

    assign o_frame_count     = r_frame_count;
    assign o_lines_per_frame = r_lines_per_frame;
`endif

endmodule

// File: tb/tb_gigatron_video_rx.sv
// -----------------------------------------------------------------------------
// tb_gigatron_video_rx
// Directed bench for gigatron_video_rx. Vertical timing is shortened
// (V_BP=4, V_ACTIVE=20) so full frames stay short; horizontal timing is the
// default. Each line is 200 samples: hsync low for samples 0..9, rising at
// sample 10 (h=0), colour = h[5:0].
// -----------------------------------------------------------------------------
module tb_gigatron_video_rx;

    localparam int TB_V_BP     = 4;
    localparam int TB_V_ACT    = 20;
    localparam int LINE_LEN    = 200;
    localparam int FRAME_LINES = 2 + TB_V_BP + TB_V_ACT + 2;

    logic       i_clock = 1'b0;
    logic       i_reset_n = 1'b0;
    logic       i_valid = 1'b0;
    logic [7:0] i_out = 8'hC0;
    logic       o_px_valid;
    logic [7:0] o_px_x;
    logic [8:0] o_px_y;
    logic [5:0] o_px_rgb;
    logic       o_frame_start;
    logic       o_short_frame;
`ifdef GIGATRON_VIDEO_RX_STATS_EN
    logic [15:0] o_frame_count;
    logic [9:0]  o_lines_per_frame;
`endif

    gigatron_video_rx #(
        .H_BP     (12),
        .H_ACTIVE (160),
        .V_BP     (TB_V_BP),
        .V_ACTIVE (TB_V_ACT)
    ) dut (
        .i_clock       (i_clock),
        .i_reset_n     (i_reset_n),
        .i_valid       (i_valid),
        .i_out         (i_out),
        .o_px_valid    (o_px_valid),
        .o_px_x        (o_px_x),
        .o_px_y        (o_px_y),
        .o_px_rgb      (o_px_rgb),
        .o_frame_start (o_frame_start),
        .o_short_frame (o_short_frame)
`ifdef GIGATRON_VIDEO_RX_STATS_EN
        ,
        .o_frame_count     (o_frame_count),
        .o_lines_per_frame (o_lines_per_frame)
`endif
    );

    always #5 i_clock = ~i_clock;

    int n_cmp = 0;
    int n_mis = 0;

    // Tallies gathered while stimulus runs
    int t_px, t_fs, t_short, t_fs_short, t_inval_px, t_order_err;
    int f_x, f_y, f_rgb, l_x, l_y, l_rgb;
    int exp_x, exp_y;

    task automatic check_eq(input string tag, input int obs, input int exp_v);
        n_cmp++;
        if (obs != exp_v) begin
            n_mis++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic clr(input int start_y);
        t_px = 0; t_fs = 0; t_short = 0; t_fs_short = 0;
        t_inval_px = 0; t_order_err = 0;
        f_x = -1; f_y = -1; f_rgb = -1; l_x = -1; l_y = -1; l_rgb = -1;
        exp_x = 0; exp_y = start_y;
    endtask

    // One clock: drive, step past the edge, record what the DUT produced
    task automatic cyc(input logic v, input logic [7:0] d);
        i_valid = v;
        i_out   = d;
        @(posedge i_clock);
        #1;
        if (o_px_valid) begin
            if (!v) t_inval_px++;
            if (t_px == 0) begin
                f_x = int'(o_px_x); f_y = int'(o_px_y); f_rgb = int'(o_px_rgb);
            end
            l_x = int'(o_px_x); l_y = int'(o_px_y); l_rgb = int'(o_px_rgb);
            if (int'(o_px_x) != exp_x || int'(o_px_y) != exp_y) t_order_err++;
            exp_x++;
            if (exp_x == 160) begin
                exp_x = 0;
                exp_y++;
            end
            t_px++;
        end
        if (o_frame_start) t_fs++;
        if (o_short_frame) t_short++;
        if (o_frame_start && o_short_frame) t_fs_short++;
    endtask

    // vsync = vs_a before sample 'split', vs_b from it; hsync high on [10, hs_end)
    task automatic send_line(input int len, input logic vs_a, input logic vs_b,
                             input int split, input int hs_end, input bit tog);
        for (int c = 0; c < len; c++) begin
            logic       vs;
            logic       hs;
            logic [9:0] hv;
            logic [7:0] d;
            hs = (c >= 10) && (c < hs_end);
            vs = (c < split) ? vs_a : vs_b;
            hv = 10'(c - 10);
            d  = {vs, hs, hv[5:0]};
            if (tog) begin
                cyc(1'b1, d);
                cyc(1'b0, ~d);
            end else begin
                cyc(1'b1, d);
            end
        end
    endtask

    task automatic frame(input int n_lines, input int len);
        for (int k = 0; k < n_lines; k++) begin
            send_line(len, (k >= 2), (k >= 2), 0, len, 1'b0);
        end
    endtask

    task automatic do_reset(input string tag);
        i_reset_n = 1'b0;
        i_valid   = 1'b0;
        i_out     = 8'hC0;
        repeat (3) @(posedge i_clock);
        #1;
        check_eq({tag, "_px_valid"}, int'(o_px_valid), 0);
        check_eq({tag, "_px_x"}, int'(o_px_x), 0);
        check_eq({tag, "_px_y"}, int'(o_px_y), 0);
        check_eq({tag, "_px_rgb"}, int'(o_px_rgb), 0);
        check_eq({tag, "_frame_start"}, int'(o_frame_start), 0);
        check_eq({tag, "_short_frame"}, int'(o_short_frame), 0);
`ifdef GIGATRON_VIDEO_RX_STATS_EN
        check_eq({tag, "_frame_count"}, int'(o_frame_count), 0);
`endif
        i_reset_n = 1'b1;
        @(posedge i_clock);
        #1;
    endtask

    initial begin
        // Reset state
        do_reset("rst");

        // Idle sync lines after release: nothing happens
        clr(0);
        repeat (1000) cyc(1'b1, 8'hC0);
        check_eq("idle_px", t_px, 0);
        check_eq("idle_fs", t_fs, 0);

        // Complete frame
        clr(0);
        frame(FRAME_LINES, LINE_LEN);
        check_eq("frame_px", t_px, 160 * TB_V_ACT);
        check_eq("frame_first_x", f_x, 0);
        check_eq("frame_first_y", f_y, 0);
        check_eq("frame_first_rgb", f_rgb, 12);
        check_eq("frame_last_x", l_x, 159);
        check_eq("frame_last_y", l_y, TB_V_ACT - 1);
        check_eq("frame_last_rgb", l_rgb, 43);
        check_eq("frame_order", t_order_err, 0);
        check_eq("frame_fs", t_fs, 1);
        check_eq("frame_short", t_short, 0);

        // Frame cut by vsync in row 10, sample 50
        clr(0);
        for (int k = 0; k < 16; k++) begin
            send_line(LINE_LEN, (k >= 2), (k >= 2), 0, LINE_LEN, 1'b0);
        end
        send_line(LINE_LEN, 1'b1, 1'b0, 50, LINE_LEN, 1'b0);
        check_eq("short_px", t_px, 1628);
        check_eq("short_last_x", l_x, 27);
        check_eq("short_last_y", l_y, 10);
        check_eq("short_order", t_order_err, 0);
        check_eq("short_fs", t_fs, 2);
        check_eq("short_pulse", t_short, 1);
        check_eq("short_same_cycle", t_fs_short, 1);
        clr(0);
        send_line(LINE_LEN, 1'b0, 1'b0, 0, LINE_LEN, 1'b0);
        for (int k = 0; k < TB_V_BP; k++) begin
            send_line(LINE_LEN, 1'b1, 1'b1, 0, LINE_LEN, 1'b0);
        end
        check_eq("short_vbp_px", t_px, 0);

        // First row of new frame; hsync falls mid-line without effect
        clr(0);
        send_line(LINE_LEN, 1'b1, 1'b1, 0, 100, 1'b0);
        check_eq("hsfall_px", t_px, 160);
        check_eq("hsfall_last_y", l_y, 0);
        check_eq("hsfall_order", t_order_err, 0);

        // Row 1 with i_valid toggling every cycle
        clr(1);
        send_line(LINE_LEN, 1'b1, 1'b1, 0, LINE_LEN, 1'b1);
        check_eq("tog_px", t_px, 160);
        check_eq("tog_inval_px", t_inval_px, 0);
        check_eq("tog_order", t_order_err, 0);
        check_eq("tog_first_x", f_x, 0);
        check_eq("tog_last_x", l_x, 159);

        // hsync and vsync fall together in VBP: receiver must wait for vsync rise
        for (int k = 0; k < 4; k++) begin
            send_line(LINE_LEN, (k >= 2), (k >= 2), 0, LINE_LEN, 1'b0);
        end
        clr(0);
        for (int k = 0; k < 6; k++) begin
            send_line(LINE_LEN, 1'b0, 1'b0, 0, LINE_LEN, 1'b0);
        end
        check_eq("coinc_fs", t_fs, 1);
        check_eq("coinc_short", t_short, 0);
        check_eq("coinc_px", t_px, 0);

        // Reset in the middle of an active frame
        clr(0);
        for (int k = 0; k < 8; k++) begin
            send_line(LINE_LEN, (k >= 2), (k >= 2), 0, LINE_LEN, 1'b0);
        end
        check_eq("pre_rst_px", t_px, 320);
        check_eq("pre_rst_fs", t_fs, 0);
        do_reset("midrst");
        clr(0);
        for (int k = 0; k < 4; k++) begin
            send_line(LINE_LEN, 1'b1, 1'b1, 0, LINE_LEN, 1'b0);
        end
        check_eq("post_rst_px", t_px, 0);

`ifdef GIGATRON_VIDEO_RX_STATS_EN
        // Three frames of 525 short lines
        do_reset("stats_rst");
        repeat (5) cyc(1'b1, 8'hC0);
        for (int f = 0; f < 3; f++) begin
            frame(525, 20);
        end
        check_eq("stats_frame_count", int'(o_frame_count), 3);
        check_eq("stats_lines", int'(o_lines_per_frame), 525);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
